cv32e40x_mul_issue: RTL and testbench

//  Issue/retire stage in front of the multiplier (cv32e40x_mult) in EX.
//  - Takes MUL/MULH/MULHSU/MULHU from ID; decodes operator_i/short_signed_i.
//  - Holds operands and valid stable for the whole multi-cycle MULH sequence.
//  - Owns the flush path, so a killed MULH cannot corrupt the multiplier FSM.
//  - Registers the 32-bit product plus destination tag for writeback.

---
 rtl/cv32e40x_mul_issue.sv | 218 +++++++++++++++++++++
 tb/tb_cv32e40x_mul_issue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_mul_issue.sv
// cv32e40x_mul_issue
//
// Issue/retire stage that sits in EX in front of the multiplier
// (cv32e40x_mult). It accepts one MUL/MULH/MULHSU/MULHU from ID and decodes
// funct3 into the multiplier's operator/short_signed controls. Operands and
// valid are held stable for the whole multi-cycle MULH sequence. The stage
// owns the flush path so a killed MULH never leaves the multiplier FSM in a
// half-finished state. The 32-bit product and its destination tag are
// registered for writeback.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   id_valid_i / id_ready_o     op handshake from ID
//   id_funct3_i                 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   id_op_a_i / id_op_b_i       rs1 / rs2 values
//   id_tag_i                    destination tag (rd index)
//   kill_i                      flush the in-flight op (wb entry unaffected)
//   mul_valid_o / mul_ready_o   handshake towards the multiplier
//   mul_operator_o              MUL_M32 for funct3 00, MUL_H otherwise
//   mul_short_signed_o          [0]=op_a signed, [1]=op_b signed
//   mul_op_a_o / mul_op_b_o     held operands
//   mul_valid_i / mul_result_i  multiplier result handshake
//   wb_valid_o / wb_ready_i     writeback handshake
//   wb_result_o / wb_tag_o      registered product and its tag
//
// Handshakes: every valid/ready pair transfers on a cycle where both are high
// at the rising clock edge. A producer keeps valid and its payload stable
// until the transfer happens (or, on the multiplier side, until a kill).

package cv32e40x_mul_pkg;
   typedef enum logic {
      MUL_M32 = 1'b0,
      MUL_H   = 1'b1
   } mul_opcode_e;
endpackage

module cv32e40x_mul_issue
   import cv32e40x_mul_pkg::*;
#(
   parameter int unsigned TAG_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   // ID side
   input  logic               id_valid_i,
   output logic               id_ready_o,
   input  logic [1:0]         id_funct3_i,
   input  logic [31:0]        id_op_a_i,
   input  logic [31:0]        id_op_b_i,
   input  logic [TAG_W-1:0]   id_tag_i,
   input  logic               kill_i,
   // multiplier side
   output logic               mul_valid_o,
   output mul_opcode_e        mul_operator_o,
   output logic [1:0]         mul_short_signed_o,
   output logic [31:0]        mul_op_a_o,
   output logic [31:0]        mul_op_b_o,
   input  logic               mul_valid_i,
   output logic               mul_ready_o,
   input  logic [31:0]        mul_result_i,
   // writeback side
   output logic               wb_valid_o,
   input  logic               wb_ready_i,
   output logic [31:0]        wb_result_o,
   output logic [TAG_W-1:0]   wb_tag_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [31:0]        op_a_q, op_b_q;
   logic [1:0]         funct3_q;
   logic [TAG_W-1:0]   tag_q;
   logic               wb_valid_q, wb_valid_d;
   logic [31:0]        wb_result_q;
   logic [TAG_W-1:0]   wb_tag_q;

   logic               is_mul;
   logic               complete;
   logic               accept;

   assign is_mul = (funct3_q == 2'b00);

   // Operator decode from the held funct3.
   always_comb begin
      mul_operator_o     = is_mul ? MUL_M32 : MUL_H;
      mul_short_signed_o = 2'b00;
      case (funct3_q)
         2'b01:   mul_short_signed_o = 2'b11;   // MULH:   signed x signed
         2'b10:   mul_short_signed_o = 2'b01;   // MULHSU: signed x unsigned
         default: mul_short_signed_o = 2'b00;   // MUL, MULHU
      endcase
   end

   assign mul_op_a_o  = op_a_q;
   assign mul_op_b_o  = op_b_q;
   assign wb_valid_o  = wb_valid_q;
   assign wb_result_o = wb_result_q;
   assign wb_tag_o    = wb_tag_q;

   // Handshake outputs and next state.
   always_comb begin
      mul_valid_o = 1'b0;
      mul_ready_o = 1'b0;
      complete    = 1'b0;
      id_ready_o  = 1'b0;
      accept      = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;

      case (state_q)
         S_ISSUE: begin
            // A kill before the multiplier has left ALBL must keep valid low,
            // otherwise its FSM would step into a sequence nobody completes.
            mul_valid_o = !(kill_i && (is_mul || cnt_q == 2'd0));
            // A kill in the final MULH cycle still has to pop the result out
            // of the multiplier so it returns to ALBL.
            mul_ready_o = !wb_valid_q || wb_ready_i ||
                          (kill_i && !is_mul && cnt_q == 2'd3);
            complete    = mul_valid_i && mul_ready_o && !kill_i;
            id_ready_o  = complete;
         end
         S_DRAIN: begin
            mul_valid_o = 1'b1;
            mul_ready_o = 1'b1;
         end
         default: begin
            id_ready_o = !kill_i;
         end
      endcase

      accept = id_valid_i && id_ready_o;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_ISSUE;
               cnt_d   = 2'd0;
            end
         end
         S_ISSUE: begin
            if (kill_i) begin
               // MULH killed mid-sequence: multiplier is past ALBL and before
               // AHBH, so let it run out in DRAIN.
               if (!is_mul && (cnt_q == 2'd1 || cnt_q == 2'd2)) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = 2'd0;
               end
            end else if (complete) begin
               state_d = accept ? S_ISSUE : S_IDLE;
               cnt_d   = 2'd0;
            end else if (!is_mul && cnt_q != 2'd3) begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_DRAIN: begin
            if (mul_valid_i) begin
               state_d = S_IDLE;
               cnt_d   = 2'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_comb begin
      wb_valid_d = wb_valid_q;
      if (complete) begin
         wb_valid_d = 1'b1;
      end else if (wb_ready_i) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         op_a_q      <= 32'd0;
         op_b_q      <= 32'd0;
         funct3_q    <= 2'b00;
         tag_q       <= '0;
         wb_valid_q  <= 1'b0;
         wb_result_q <= 32'd0;
         wb_tag_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wb_valid_q <= wb_valid_d;
         if (accept) begin
            op_a_q   <= id_op_a_i;
            op_b_q   <= id_op_b_i;
            funct3_q <= id_funct3_i;
            tag_q    <= id_tag_i;
         end
         if (complete) begin
            wb_result_q <= mul_result_i;
            wb_tag_q    <= tag_q;
         end
      end
   end

   // The multiplier answers a MUL in its first cycle and a MULH only from AHBH.
   a_mul_valid_timing: assert property (@(posedge clk) disable iff (rst)
      (state_q == S_ISSUE && mul_valid_i) |->
         (is_mul ? (cnt_q == 2'd0) : (cnt_q == 2'd3)));

endmodule

// File: tb/tb_cv32e40x_mul_issue.sv
// Bench for cv32e40x_mul_issue: a behavioural multiplier drives the result
// side, a queue of expected {tag, product} retires against wb handshakes, and
// directed scenarios pin latency and literal results.

module tb_cv32e40x_mul_issue;
   import cv32e40x_mul_pkg::*;

   localparam int unsigned TAG_W = 5;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT signals
   logic               id_valid_i = 1'b0;
   logic               id_ready_o;
   logic [1:0]         id_funct3_i = 2'b00;
   logic [31:0]        id_op_a_i = 32'd0;
   logic [31:0]        id_op_b_i = 32'd0;
   logic [TAG_W-1:0]   id_tag_i = '0;
   logic               kill_i = 1'b0;
   logic               mul_valid_o;
   mul_opcode_e        mul_operator_o;
   logic [1:0]         mul_short_signed_o;
   logic [31:0]        mul_op_a_o, mul_op_b_o;
   logic               mul_valid_i;
   logic               mul_ready_o;
   logic [31:0]        mul_result_i;
   logic               wb_valid_o;
   logic               wb_ready_i = 1'b1;
   logic [31:0]        wb_result_o;
   logic [TAG_W-1:0]   wb_tag_o;

   cv32e40x_mul_issue #(.TAG_W(TAG_W)) dut (
      .clk                (clk),
      .rst                (rst),
      .id_valid_i         (id_valid_i),
      .id_ready_o         (id_ready_o),
      .id_funct3_i        (id_funct3_i),
      .id_op_a_i          (id_op_a_i),
      .id_op_b_i          (id_op_b_i),
      .id_tag_i           (id_tag_i),
      .kill_i             (kill_i),
      .mul_valid_o        (mul_valid_o),
      .mul_operator_o     (mul_operator_o),
      .mul_short_signed_o (mul_short_signed_o),
      .mul_op_a_o         (mul_op_a_o),
      .mul_op_b_o         (mul_op_b_o),
      .mul_valid_i        (mul_valid_i),
      .mul_ready_o        (mul_ready_o),
      .mul_result_i       (mul_result_i),
      .wb_valid_o         (wb_valid_o),
      .wb_ready_i         (wb_ready_i),
      .wb_result_o        (wb_result_o),
      .wb_tag_o           (wb_tag_o)
   );

   // Behavioural multiplier: MUL answers combinationally, MULH walks four
   // partial-product steps and answers in the fourth until ready.
   logic [1:0]  m_st;
   logic [63:0] m_ea, m_eb, m_p;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st <= 2'd0;
      end else if (mul_valid_o && mul_operator_o == MUL_H) begin
         if (m_st != 2'd3) m_st <= m_st + 2'd1;
         else if (mul_ready_o) m_st <= 2'd0;
      end
   end

   always_comb begin
      m_ea = mul_short_signed_o[0] ? {{32{mul_op_a_o[31]}}, mul_op_a_o} : {32'd0, mul_op_a_o};
      m_eb = mul_short_signed_o[1] ? {{32{mul_op_b_o[31]}}, mul_op_b_o} : {32'd0, mul_op_b_o};
      m_p  = m_ea * m_eb;
      mul_result_i = (mul_operator_o == MUL_M32) ? m_p[31:0] : m_p[63:32];
      mul_valid_i  = mul_valid_o && (mul_operator_o == MUL_M32 || m_st == 2'd3);
   end

   // scoreboard
   int n_checks = 0;
   int n_errors = 0;
   logic [TAG_W+31:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Architectural result of a RISC-V M-extension multiply.
   function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (f == 2'b01 || f == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
      eb = (f == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ea * eb;
      return (f == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // compare process: every wb handshake retires the oldest expectation, and
   // a stalled wb entry must not change
   logic               prev_hold = 1'b0;
   logic [31:0]        prev_res;
   logic [TAG_W-1:0]   prev_tag;
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("wb_hold_valid", wb_valid_o, 1);
            check("wb_hold_result", wb_result_o, prev_res);
            check("wb_hold_tag", wb_tag_o, prev_tag);
         end
         if (wb_valid_o && wb_ready_i) begin
            if (exp_q.size() == 0) begin
               check("wb_unexpected", wb_valid_o, 0);
            end else begin
               logic [TAG_W+31:0] e;
               e = exp_q.pop_front();
               check("wb_result", wb_result_o, e[31:0]);
               check("wb_tag", wb_tag_o, e[TAG_W+31:32]);
            end
         end
         prev_hold = wb_valid_o && !wb_ready_i;
         prev_res  = wb_result_o;
         prev_tag  = wb_tag_o;
      end
   end

   // driver tasks (called in the phase just after a rising edge)
   task automatic drive_id(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t);
      id_valid_i  = 1'b1;
      id_funct3_i = f;
      id_op_a_i   = a;
      id_op_b_i   = b;
      id_tag_i    = t;
   endtask

   task automatic push_exp();
      exp_q.push_back({id_tag_i, model(id_funct3_i, id_op_a_i, id_op_b_i)});
   endtask

   task automatic issue_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t);
      int n;
      n = 0;
      drive_id(f, a, b, t);
      forever begin
         @(negedge clk);
         if (id_ready_o) break;
         n++;
         if (n > 200) begin
            check("accept_timeout", id_ready_o, 1);
            break;
         end
         @(posedge clk);
      end
      if (id_ready_o) push_exp();
      @(posedge clk); #1;
      id_valid_i = 1'b0;
   endtask

   task automatic expect_wb(input string name, input int lat, input logic [1:0] ss,
                            input logic opc, input logic [31:0] res,
                            input logic [TAG_W-1:0] t);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == 1) begin
            check({name, "_mul_valid"}, mul_valid_o, 1);
            check({name, "_short_signed"}, mul_short_signed_o, ss);
            check({name, "_operator"}, mul_operator_o, opc);
         end
         if (k < lat) begin
            check({name, "_wb_early"}, wb_valid_o, 0);
         end else begin
            check({name, "_wb_valid"}, wb_valid_o, 1);
            check({name, "_wb_result"}, wb_result_o, res);
            check({name, "_wb_tag"}, wb_tag_o, t);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_id_ready", id_ready_o, 1);
      check("rst_wb_valid", wb_valid_o, 0);
      check("rst_mul_valid", mul_valid_o, 0);
      check("rst_wb_result", wb_result_o, 0);
      check("rst_wb_tag", wb_tag_o, 0);
      check("rst_op_a", mul_op_a_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // MUL latency and value
      issue_op(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5);
      expect_wb("mul", 2, 2'b00, MUL_M32, 32'hFFFF_FFEB, 5'd5);

      // high-word variants
      issue_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd6);
      expect_wb("mulh", 5, 2'b11, MUL_H, 32'h4000_0000, 5'd6);
      issue_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
      expect_wb("mulhu", 5, 2'b00, MUL_H, 32'hFFFF_FFFE, 5'd7);
      issue_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
      expect_wb("mulhsu", 5, 2'b01, MUL_H, 32'hFFFF_FFFF, 5'd8);

      // three back-to-back MULs with writeback stalled for four cycles
      wb_ready_i = 1'b0;
      drive_id(2'b00, 32'd2, 32'd3, 5'd1);
      @(negedge clk);
      check("b2b_accept_a", id_ready_o, 1);
      if (id_ready_o) push_exp();
      @(posedge clk); #1;
      drive_id(2'b00, 32'd4, 32'd5, 5'd2);
      @(negedge clk);
      check("b2b_accept_b", id_ready_o, 1);
      if (id_ready_o) push_exp();
      @(posedge clk); #1;
      drive_id(2'b00, 32'hFFFF_FFFF, 32'd2, 5'd3);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("b2b_stall_wb_valid", wb_valid_o, 1);
         check("b2b_stall_wb_result", wb_result_o, 32'd6);
         check("b2b_stall_mul_ready", mul_ready_o, 0);
         check("b2b_stall_id_ready", id_ready_o, 0);
         @(posedge clk); #1;
      end
      wb_ready_i = 1'b1;
      @(negedge clk);
      check("b2b_accept_c", id_ready_o, 1);
      check("b2b_retire_a", wb_result_o, 32'd6);
      if (id_ready_o) push_exp();
      @(posedge clk); #1;
      id_valid_i = 1'b0;
      @(negedge clk);
      check("b2b_retire_b_valid", wb_valid_o, 1);
      check("b2b_retire_b", wb_result_o, 32'd20);
      check("b2b_retire_b_tag", wb_tag_o, 5'd2);
      @(posedge clk); #1;
      @(negedge clk);
      check("b2b_retire_c", wb_result_o, 32'hFFFF_FFFE);
      check("b2b_retire_c_tag", wb_tag_o, 5'd3);
      @(posedge clk); #1;
      @(negedge clk);
      check("b2b_empty", wb_valid_o, 0);
      @(posedge clk); #1;

      // MULH killed at cnt 1 drains, then a MUL runs cleanly
      issue_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd4);
      @(posedge clk); #1;
      kill_i = 1'b1;
      @(negedge clk);
      check("kill1_mul_valid", mul_valid_o, 1);
      check("kill1_id_ready", id_ready_o, 0);
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      kill_i = 1'b0;
      @(negedge clk);
      check("drain_mul_valid", mul_valid_o, 1);
      check("drain_mul_ready", mul_ready_o, 1);
      check("drain_id_ready", id_ready_o, 0);
      check("drain_wb_valid", wb_valid_o, 0);
      @(posedge clk); #1;
      issue_op(2'b00, 32'd2, 32'd3, 5'd7);
      expect_wb("after_drain", 2, 2'b00, MUL_M32, 32'd6, 5'd7);

      // MULH killed at cnt 0, then a MULHU
      issue_op(2'b01, 32'd5, 32'd6, 5'd9);
      kill_i = 1'b1;
      @(negedge clk);
      check("kill0_mul_valid", mul_valid_o, 0);
      check("kill0_id_ready", id_ready_o, 0);
      void'(exp_q.pop_back());
      @(posedge clk); #1;
      kill_i = 1'b0;
      @(negedge clk);
      check("kill0_idle_id_ready", id_ready_o, 1);
      check("kill0_wb_valid", wb_valid_o, 0);
      @(posedge clk); #1;
      issue_op(2'b11, 32'h0001_0000, 32'h0001_0000, 5'd10);
      expect_wb("after_kill0", 5, 2'b00, MUL_H, 32'h0000_0001, 5'd10);

      // reset pulse at cnt 2 of a MULH
      issue_op(2'b01, 32'd3, 32'd4, 5'd11);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_mul_valid", mul_valid_o, 0);
      check("midrst_wb_valid", wb_valid_o, 0);
      check("midrst_id_ready", id_ready_o, 1);
      check("midrst_op_a", mul_op_a_o, 0);
      check("midrst_op_b", mul_op_b_o, 0);
      check("midrst_short_signed", mul_short_signed_o, 2'b00);
      check("midrst_wb_result", wb_result_o, 0);
      check("midrst_wb_tag", wb_tag_o, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
      expect_wb("after_rst", 2, 2'b00, MUL_M32, 32'h0000_0001, 5'd12);

      repeat (2) @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
